// File: rtl/fetch_pkg.sv
// Types and constants shared by fetch, the IF/ID queue and decode.
// An entry is one fetched {pc, instruction} pair.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_id_queue.sv
// In-order instruction queue between fetch and decode with a first-word-fall-through head.
// Ready toward fetch depends only on occupancy, so decode stalls never create a comb path to the PC.
module if_id_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic                       i_fetch_valid,
    input  logic [31:0]                i_fetch_pc,
    input  logic [31:0]                i_fetch_instr,
    output logic                       o_fetch_ready,
    output logic                       o_id_valid,
    output logic [31:0]                o_id_pc,
    output logic [31:0]                o_id_instr,
    input  logic                       i_id_ready,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t mem [DEPTH];
    fetch_entry_t head;

    logic [PTR_W-1:0] wptr_reg;
    logic [PTR_W-1:0] rptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;

    assign o_fetch_ready = (count_reg != FULL_CNT);
    assign o_id_valid    = (count_reg != '0);
    assign push          = i_fetch_valid & o_fetch_ready & ~i_flush;
    assign pop           = o_id_valid & i_id_ready & ~i_flush;
    assign o_count       = count_reg;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else if (i_flush) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) wptr_reg <= wptr_reg + 1'b1;
            if (pop)  rptr_reg <= rptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    // Storage is never cleared; occupancy alone decides what is live.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wptr_reg] <= '{pc: i_fetch_pc, instr: i_fetch_instr};
        end
    end

    assign head = mem[rptr_reg];

    // An empty queue shows a NOP bubble so a decode that ignores valid stays harmless.
    always_comb begin
        o_id_pc    = '0;
        o_id_instr = NOP_INSTR;
        if (o_id_valid) begin
            o_id_pc    = head.pc;
            o_id_instr = head.instr;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Table-driven bench for if_id_queue with a queue scoreboard tracking accepted pairs.
// Each vector is one cycle of fetch/decode/flush stimulus plus the occupancy expected after the edge.
module tb_if_id_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        id_ready;
        logic        flush;
        int          exp_count;
        string       tag;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          f_valid = 1'b0;
    logic [31:0]   f_pc = '0;
    logic [31:0]   f_instr = '0;
    logic          f_ready;
    logic          id_valid;
    logic [31:0]   id_pc;
    logic [31:0]   id_instr;
    logic          id_ready = 1'b0;
    logic [CW-1:0] count;

    int   checks = 0;
    int   errors = 0;
    ent_t sb[$];
    vec_t vecs[$];

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_flush       (flush),
        .i_fetch_valid (f_valid),
        .i_fetch_pc    (f_pc),
        .i_fetch_instr (f_instr),
        .o_fetch_ready (f_ready),
        .o_id_valid    (id_valid),
        .o_id_pc       (id_pc),
        .o_id_instr    (id_instr),
        .i_id_ready    (id_ready),
        .o_count       (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [31:0] pc, input logic rdy,
                       input logic fl, input int cnt, input string tag);
        vec_t x;
        x.valid = v; x.pc = pc; x.id_ready = rdy; x.flush = fl; x.exp_count = cnt; x.tag = tag;
        vecs.push_back(x);
    endtask

    // Compare the visible outputs against the scoreboard's view of the queue.
    task automatic check_state(input string tag);
        ent_t h;
        chk({tag, ":count"}, 32'(count), 32'(sb.size()));
        chk({tag, ":valid"}, 32'(id_valid), 32'(sb.size() != 0));
        chk({tag, ":ready"}, 32'(f_ready), 32'(sb.size() != DEPTH));
        if (sb.size() != 0) begin
            h = sb[0];
            chk({tag, ":pc"}, id_pc, h.pc);
            chk({tag, ":instr"}, id_instr, h.instr);
        end else begin
            chk({tag, ":pc"}, id_pc, 32'h0);
            chk({tag, ":instr"}, id_instr, 32'h0000_0013);
        end
    endtask

    // One cycle: drive after the falling edge, check before the rising edge, check count after it.
    task automatic cycle(input vec_t v, input int idx);
        logic m_push, m_pop, m_ready, m_valid;
        ent_t e;
        f_valid  = v.valid;
        f_pc     = v.pc;
        f_instr  = instr_of(v.pc);
        id_ready = v.id_ready;
        flush    = v.flush;
        #1;
        check_state(v.tag);
        m_ready = (sb.size() != DEPTH);
        m_valid = (sb.size() != 0);
        m_push  = v.valid && m_ready && !v.flush;
        m_pop   = m_valid && v.id_ready && !v.flush;
        if (v.flush) begin
            sb.delete();
        end else begin
            if (m_pop) void'(sb.pop_front());
            if (m_push) begin
                e.pc = v.pc; e.instr = instr_of(v.pc);
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        chk({v.tag, ":count_after"}, 32'(count), 32'(v.exp_count));
        $display("vec %0d %s v=%0b pc=0x%08h rdy=%0b fl=%0b push=%0b pop=%0b count=%0d",
                 idx, v.tag, v.valid, v.pc, v.id_ready, v.flush, m_push, m_pop, count);
        @(negedge clk);
    endtask

    initial begin
        // Streaming: one per cycle, occupancy holds at 1.
        add(1, 32'h0, 1, 0, 1, "stream");
        add(1, 32'h4, 1, 0, 1, "stream");
        add(1, 32'h8, 1, 0, 1, "stream");
        add(1, 32'hC, 1, 0, 1, "stream");
        add(0, 32'h0, 1, 0, 0, "stream_drain");
        // Back-pressure: fifth pair waits for the first pop.
        add(1, 32'h0,  0, 0, 1, "bp");
        add(1, 32'h4,  0, 0, 2, "bp");
        add(1, 32'h8,  0, 0, 3, "bp");
        add(1, 32'hC,  0, 0, 4, "bp");
        add(1, 32'h10, 0, 0, 4, "bp_full");
        add(1, 32'h10, 1, 0, 3, "bp_pop");
        add(1, 32'h10, 0, 0, 4, "bp_accept");
        for (int i = 0; i < 4; i++) add(0, 32'h0, 1, 0, 3 - i, "bp_drain");
        // Simultaneous push/pop at count 3.
        add(1, 32'h200, 0, 0, 1, "pp");
        add(1, 32'h204, 0, 0, 2, "pp");
        add(1, 32'h208, 0, 0, 3, "pp");
        add(1, 32'h20C, 1, 0, 3, "pp_both");
        for (int i = 0; i < 3; i++) add(0, 32'h0, 1, 0, 2 - i, "pp_drain");
        // Wrap-around at count 2.
        add(1, 32'h300, 0, 0, 1, "wrap_fill");
        add(1, 32'h304, 0, 0, 2, "wrap_fill");
        for (int i = 0; i < 10; i++) add(1, 32'h308 + 32'(4 * i), 1, 0, 2, "wrap");
        add(0, 32'h0, 1, 0, 1, "wrap_drain");
        add(0, 32'h0, 1, 0, 0, "wrap_drain");
        // Flush with same-cycle push and pop request.
        add(1, 32'h20, 0, 0, 1, "fl_fill");
        add(1, 32'h24, 0, 0, 2, "fl_fill");
        add(1, 32'h28, 0, 0, 3, "fl_fill");
        add(1, 32'h40, 1, 1, 0, "flush");
        add(1, 32'h100, 0, 0, 1, "redirect");
        add(0, 32'h0, 1, 0, 0, "redirect_drain");

        // Reset state while reset is held.
        #2;
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_valid", 32'(id_valid), 32'h0);
        chk("rst_ready", 32'(f_ready), 32'h1);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_instr", id_instr, 32'h0000_0013);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) cycle(vecs[i], i);

        // Asynchronous reset mid-cycle with three entries held.
        begin
            vec_t v;
            for (int i = 0; i < 3; i++) begin
                v.valid = 1; v.pc = 32'h500 + 32'(4 * i); v.id_ready = 0; v.flush = 0;
                v.exp_count = i + 1; v.tag = "ar_fill";
                cycle(v, vecs.size() + i);
            end
            f_valid = 1'b0;
            id_ready = 1'b0;
            @(posedge clk);
            #3;
            rst = 1'b1;
            sb.delete();
            #1;
            chk("arst_count", 32'(count), 32'h0);
            chk("arst_valid", 32'(id_valid), 32'h0);
            chk("arst_instr", id_instr, 32'h0000_0013);
            chk("arst_ready", 32'(f_ready), 32'h1);
            chk("arst_pc", id_pc, 32'h0);
            $display("async reset applied mid-cycle: count=%0d valid=%0b", count, id_valid);
            @(negedge clk);
            rst = 1'b0;
            v.valid = 1; v.pc = 32'h600; v.id_ready = 0; v.flush = 0;
            v.exp_count = 1; v.tag = "post_rst";
            cycle(v, 999);
            v.valid = 0; v.id_ready = 1; v.exp_count = 0; v.tag = "post_rst_drain";
            cycle(v, 1000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction queue between the fetch stage (program counter register plus instruction memory) and the decode stage. It accepts {pc, instruction} pairs from fetch under a valid/ready handshake and holds up to DEPTH entries in order. It presents the oldest entry to decode as a first-word-fall-through head. Its ready output gates the upstream PC update, so a decode stall back-pressures fetch without dropping or duplicating instructions.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_flush  in  1  synchronous flush (branch/jump redirect from execute)
- i_fetch_valid  in  1  fetch presents a valid pair this cycle
- i_fetch_pc  in  32  PC of fetched instruction
- i_fetch_instr  in  32  fetched instruction word
- o_fetch_ready  out  1  queue can accept; drives upstream PC enable (1 = PC advances)
- o_id_valid  out  1  head entry valid for decode
- o_id_pc  out  32  head PC
- o_id_instr  out  32  head instruction
- i_id_ready  in  1  decode consumes head this cycle
- o_count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: DEPTH-entry circular buffer, write pointer, read pointer, occupancy counter; pointers $clog2(DEPTH) bits, wrap naturally modulo DEPTH.
- push = i_fetch_valid & o_fetch_ready & !i_flush; pop = o_id_valid & i_id_ready & !i_flush.
- o_fetch_ready = (count != DEPTH); depends only on registered state, never on i_id_ready (no combinational fetch↔decode path).
- o_id_valid = (count != 0); o_id_pc/o_id_instr = head entry when valid.
- Empty: o_id_pc = 0, o_id_instr = NOP (0x0000_0013, addi x0,x0,0), so a decode that ignores valid sees a bubble.
- push only: count+1, write at wptr, wptr+1. pop only: count−1, rptr+1. push and pop together: both pointers advance, count unchanged (legal at any nonzero count below DEPTH; at full, push is blocked, so pop alone occurs).
- Flush: next cycle count = 0 and rptr = wptr = 0. The same-cycle fetch input is discarded and the same-cycle head is not consumed. Flush dominates push/pop.
- Entry contents are not cleared on flush or pop; only pointers and count change.
- Reset mid-operation: all state immediately cleared regardless of clock; in-flight entries are lost.

## Timing
- Reset values: count 0, pointers 0, o_fetch_ready 1, o_id_valid 0, o_id_pc 0, o_id_instr NOP, o_count 0.
- Latency: a pair pushed on edge N is visible at the head from edge N onward, when the queue was empty (1-cycle fetch→decode).
- Throughput: 1 entry/cycle sustained with i_id_ready held high.
- Full: o_fetch_ready low from the edge count reaches DEPTH. Returns high the cycle after the first pop.
- After flush edge: o_id_valid 0 and o_fetch_ready 1 in the following cycle. A redirected PC can push that cycle.

## Structure
- Shared package fetch_pkg: NOP_INSTR constant (32'h0000_0013); packed struct fetch_entry_t {logic [31:0] pc; logic [31:0] instr}. Upstream fetch and decode reuse both.
- Single module; storage array of fetch_entry_t. Pointer/count logic inline; no sub-module needed.

## Test plan
- Reset: assert i_rst mid-cycle with 3 entries held -> o_count 0, o_id_valid 0, o_id_instr 0x00000013, o_fetch_ready 1 asynchronously.
- Streaming: push pc 0x0,0x4,0x8,0xC with i_id_ready=1 -> decode sees same order, one per cycle, first at cycle after push, o_count stays 1.
- Back-pressure: i_id_ready=0, push 5 pairs (DEPTH=4) -> o_fetch_ready falls after 4th; 5th (pc 0x10) not accepted; after one pop it is accepted; drain order 0x0..0x10.
- Wrap-around: 10 push/pop cycles at count 2 -> pointers wrap, order and data intact (instr = pc ^ 0xA5A5_0000).
- Flush: 3 entries, assert i_flush together with i_fetch_valid (pc 0x40) and i_id_ready -> next cycle count 0, pc 0x40 not stored, head not consumed; next push pc 0x100 appears at head.
- Simultaneous push/pop at count 3 -> count stays 3, new entry appended at tail.
